// File: rtl/eth_fcs_check.sv
// Receive-side Ethernet FCS checker: runs CRC32 over the whole frame,
// strips the trailing 4 FCS bytes and flags bad frames on the last payload beat.
module eth_fcs_check #(
    parameter int          MIN_LEN = 5,
    parameter logic [31:0] RESIDUE = 32'hDEBB20E3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       err_bad_fcs,
    output logic       err_short
);

    localparam int CW = $clog2(MIN_LEN + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(4);
    localparam logic [CW-1:0] CNT_LONG = CW'(MIN_LEN - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MIN_LEN);

    function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                             input logic [7:0]  d);
        logic [31:0] r;
        r = c ^ {24'b0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    logic             run_q;
    logic [31:0]      crc_q, crc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0][7:0]  dl_q, dl_d;
    logic             bad_q, bad_d;
    logic [7:0]       od_q, od_d;
    logic             ov_q, ov_d;
    logic             ol_q, ol_d;
    logic             ou_q, ou_d;
    logic             eb_q, eb_d;
    logic             es_q, es_d;

    logic             ready;
    logic             acc;
    logic             full;
    logic             long_f;
    logic             mism;
    logic             load;
    logic [31:0]      crc_nxt;

    always_comb begin
        ready   = !rst && run_q && (!ov_q || m_axis_tready);
        acc     = s_axis_tvalid && ready;
        crc_nxt = crc_byte(crc_q, s_axis_tdata);
        full    = cnt_q >= CNT_FULL;
        long_f  = cnt_q >= CNT_LONG;
        mism    = crc_nxt != RESIDUE;
        load    = acc && full && (!s_axis_tlast || long_f);

        crc_d = crc_q;
        cnt_d = cnt_q;
        dl_d  = dl_q;
        bad_d = bad_q;
        od_d  = od_q;
        ov_d  = ov_q;
        ol_d  = ol_q;
        ou_d  = ou_q;
        eb_d  = 1'b0;
        es_d  = 1'b0;

        if (ov_q && m_axis_tready) begin
            ov_d = 1'b0;
            ol_d = 1'b0;
            ou_d = 1'b0;
        end

        // dl_q[3] is the oldest byte once four are held
        if (load) begin
            od_d = dl_q[3];
            ov_d = 1'b1;
            ol_d = s_axis_tlast;
            ou_d = s_axis_tlast && (bad_q || s_axis_tuser || mism);
        end

        if (acc) begin
            if (s_axis_tlast) begin
                crc_d = 32'hFFFFFFFF;
                cnt_d = '0;
                dl_d  = '0;
                bad_d = 1'b0;
                eb_d  = long_f && mism;
                es_d  = !long_f;
            end else begin
                crc_d = crc_nxt;
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                dl_d  = {dl_q[2:0], s_axis_tdata};
                bad_d = bad_q || s_axis_tuser;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            crc_q <= 32'hFFFFFFFF;
            cnt_q <= '0;
            dl_q  <= '0;
            bad_q <= 1'b0;
            od_q  <= '0;
            ov_q  <= 1'b0;
            ol_q  <= 1'b0;
            ou_q  <= 1'b0;
            eb_q  <= 1'b0;
            es_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            crc_q <= crc_d;
            cnt_q <= cnt_d;
            dl_q  <= dl_d;
            bad_q <= bad_d;
            od_q  <= od_d;
            ov_q  <= ov_d;
            ol_q  <= ol_d;
            ou_q  <= ou_d;
            eb_q  <= eb_d;
            es_q  <= es_d;
        end
    end

    assign s_axis_tready = ready;
    assign m_axis_tdata  = od_q;
    assign m_axis_tvalid = ov_q;
    assign m_axis_tlast  = ol_q;
    assign m_axis_tuser  = ou_q;
    assign err_bad_fcs   = eb_q;
    assign err_short     = es_q;

endmodule

// File: tb/tb_eth_fcs_check.sv
// Bench for eth_fcs_check: directed and random frames against a
// frame-level reference model (payload CRC compared with received FCS).
module tb_eth_fcs_check;

    localparam int MIN_LEN = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_tready;
    logic       s_last;
    logic       s_user;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic       m_user;
    logic       err_bad_fcs;
    logic       err_short;

    eth_fcs_check #(.MIN_LEN(MIN_LEN), .RESIDUE(32'hDEBB20E3)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_data),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_last),
        .s_axis_tuser  (s_user),
        .m_axis_tdata  (m_data),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tlast  (m_last),
        .m_axis_tuser  (m_user),
        .err_bad_fcs   (err_bad_fcs),
        .err_short     (err_short)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_eb  = 0;
    int n_es  = 0;
    int exp_eb = 0;
    int exp_es = 0;
    int rmode = 0;
    int rcnt  = 0;
    logic [9:0] got[$];
    logic [9:0] exp_q[$];
    logic       hold_p = 1'b0;
    logic [9:0] hold_v = '0;
    logic       rst_d  = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        rcnt++;
        case (rmode)
            1: m_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
            2: m_ready = ($urandom_range(0, 3) != 0);
            default: m_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (hold_p) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", 32'({m_data, m_last, m_user}), 32'(hold_v));
            end
            if (m_valid && !m_last)
                check("tuser_nonlast", 32'(m_user), 32'd0);
            if (!rst_d)
                check("s_ready", 32'(s_tready), 32'(!m_valid || m_ready));
            if (m_valid && m_ready)
                got.push_back({m_data, m_last, m_user});
            if (err_bad_fcs) n_eb++;
            if (err_short) n_es++;
            hold_p = m_valid && !m_ready;
            hold_v = {m_data, m_last, m_user};
        end else begin
            hold_p = 1'b0;
        end
        rst_d = rst;
    end

    function automatic logic [31:0] crc32(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'b0, b[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Expected output: payload = all but last 4 bytes, bad if FCS != CRC(payload)
    task automatic model(input logic [7:0] f[$], input logic u[$]);
        int L;
        logic anyu;
        logic bad;
        logic [7:0] p[$];
        logic [31:0] fcs;
        L = f.size();
        anyu = 1'b0;
        foreach (u[i]) anyu |= u[i];
        if (L < MIN_LEN) begin
            exp_es++;
        end else begin
            for (int i = 0; i < L - 4; i++) p.push_back(f[i]);
            fcs = {f[L-1], f[L-2], f[L-3], f[L-4]};
            bad = crc32(p) != fcs;
            if (bad) exp_eb++;
            for (int i = 0; i < L - 4; i++)
                exp_q.push_back({f[i], i == L - 5, (i == L - 5) && (bad || anyu)});
        end
    endtask

    task automatic put(input logic [7:0] d, input logic l, input logic u);
        logic ok;
        int n;
        s_data = d;
        s_last = l;
        s_user = u;
        s_valid = 1'b1;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 1000) begin
            @(negedge clk);
            ok = s_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check("accept_wait", 32'(ok), 32'd1);
        s_valid = 1'b0;
        s_last = 1'b0;
        s_user = 1'b0;
    endtask

    task automatic send(input logic [7:0] f[$], input logic u[$], input int maxgap);
        int g;
        for (int i = 0; i < f.size(); i++) begin
            put(f[i], i == f.size() - 1, u[i]);
            g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (got.size() < exp_q.size() && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (8) @(posedge clk);
        #1;
        check({tag, "_beats"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check({tag, "_beat"}, 32'(got[i]), 32'(exp_q[i]));
        check({tag, "_err_bad"}, 32'(n_eb), 32'(exp_eb));
        check({tag, "_err_short"}, 32'(n_es), 32'(exp_es));
        got.delete();
        exp_q.delete();
        n_eb = 0;
        n_es = 0;
        exp_eb = 0;
        exp_es = 0;
    endtask

    logic [7:0] gf[$];
    logic [7:0] f[$];
    logic       z[$];
    logic       u[$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nl;
        int L;
        logic [7:0] p[$];
        logic [31:0] c;
        rst = 1'b1;
        s_data = '0;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_user = 1'b0;
        m_ready = 1'b1;
        gf = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
              8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        z = {};
        foreach (gf[i]) z.push_back(1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 32'(s_tready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_user", 32'(m_user), 32'd0);
        check("rst_errs", 32'({err_bad_fcs, err_short}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_still_low", 32'(s_tready), 32'd0);
        @(negedge clk);
        check("ready_rises", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1;

        model(gf, z);
        send(gf, z, 0);
        drain("good");

        f = gf;
        f[12] = 8'hCA;
        model(f, z);
        send(f, z, 0);
        drain("badfcs");

        f = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        u = {1'b0, 1'b0, 1'b0, 1'b0};
        model(f, u);
        send(f, u, 0);
        model(gf, z);
        send(gf, z, 0);
        drain("short");

        rmode = 1;
        model(gf, z);
        send(gf, z, 0);
        drain("bp");
        rmode = 0;

        u = z;
        u[2] = 1'b1;
        model(gf, u);
        send(gf, u, 0);
        drain("uerr");

        for (int i = 0; i < 6; i++) put(gf[i], 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        nl = 0;
        foreach (got[i]) if (got[i][1]) nl++;
        check("abort_tlast", 32'(nl), 32'd0);
        got.delete();
        n_eb = 0;
        n_es = 0;
        model(gf, z);
        model(gf, z);
        send(gf, z, 0);
        send(gf, z, 0);
        drain("b2b");

        rmode = 2;
        for (int k = 0; k < 40; k++) begin
            L = $urandom_range(1, 24);
            f = {};
            u = {};
            p = {};
            if (L >= MIN_LEN) begin
                for (int i = 0; i < L - 4; i++) p.push_back(8'($urandom));
                c = crc32(p);
                f = p;
                f.push_back(c[7:0]);
                f.push_back(c[15:8]);
                f.push_back(c[23:16]);
                f.push_back(c[31:24]);
                if ($urandom_range(0, 3) == 0)
                    f[$urandom_range(0, L - 1)] ^= 8'h10;
            end else begin
                for (int i = 0; i < L; i++) f.push_back(8'($urandom));
            end
            for (int i = 0; i < L; i++) u.push_back($urandom_range(0, 15) == 0);
            model(f, u);
            send(f, u, 2);
        end
        drain("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
